vga_scan_engine: RTL

- Display-side stage that consumes the 160x120x1 frame buffer written from the bus side.
- Generates 640x480@60 VGA timing from the 100 MHz system clock and drives the frame buffer's B-port clock and address.
- Maps each 1-bit pixel to one of two 8-bit colours and drives HS, VS and COLOUR.
- Emits a one-cycle start-of-frame pulse and a frame counter for the bus/processor side.

---
 rtl/vga_scan_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 51 +++++
 rtl/vga_scan_engine.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg
// Purpose: shared constants for the VGA scan engine: default 640x480@60
//   timing, derived line/frame totals and sync windows, output pipeline
//   latency, frame-buffer geometry and the axis counter width.
// Ports: none (package).
package vga_scan_pkg;

  localparam int CNT_W   = 10;
  localparam int CLK_DIV = 4;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic SYNC_ACTIVE = 1'b0;

  // Ticks from counter value to visible output: one for the address
  // register, one for the frame-buffer read feeding the colour register.
  localparam int PIPE_LAT = 2;

  localparam int FB_COLS = 160;
  localparam int FB_ROWS = 120;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// Purpose: one scan axis (horizontal or vertical). Counts 0..VIS+FP+SYNC+BP-1
//   while enabled, wrapping to 0, and decodes the raw sync and visible windows.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            advance the count by one
//   o_count         current position on the axis
//   o_wrap          high when enabled at the last position (count returns to 0)
//   o_sync_raw      VIS+FP <= count < VIS+FP+SYNC
//   o_vis_raw       count < VIS
module vga_axis_counter
  import vga_scan_pkg::*;
#(
  parameter int VIS  = 640,
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_sync_raw,
  output logic             o_vis_raw
);

  localparam logic [CNT_W-1:0] L_LAST       = CNT_W'(VIS + FP + SYNC + BP - 1);
  localparam logic [CNT_W-1:0] L_SYNC_START = CNT_W'(VIS + FP);
  localparam logic [CNT_W-1:0] L_SYNC_END   = CNT_W'(VIS + FP + SYNC);
  localparam logic [CNT_W-1:0] L_VIS        = CNT_W'(VIS);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == L_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_count    = r_count;
  assign o_wrap     = i_en && w_at_last;
  assign o_sync_raw = (r_count >= L_SYNC_START) && (r_count < L_SYNC_END);
  assign o_vis_raw  = (r_count < L_VIS);

endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine
// Purpose: display side of the 160x120x1 frame buffer. Divides CLK down to
//   the pixel rate, scans 640x480 VGA timing, reads the frame buffer (each
//   buffer pixel covers a 4x4 block of display pixels) and drives sync and
//   colour with all outputs aligned PIPE_LAT ticks behind the counters.
// Ports:
//   CLK             system clock
//   RESET           asynchronous active-low reset
//   CONFIG_COLOURS  [15:8] foreground (pixel=1), [7:0] background (pixel=0)
//   DPR_CLK         frame-buffer B-port read clock (divider MSB)
//   VGA_ADDR        frame-buffer read address {row[6:0], col[7:0]}
//   VGA_DATA        frame-buffer read data
//   VGA_HS, VGA_VS  sync outputs, SYNC_ACTIVE level during the pulse
//   VGA_COLOUR      8-bit pixel colour, 0 while blanking
//   FRAME_START     one-CLK pulse after the counters wrap to 0,0
//   FRAME_COUNT     frames since reset, wraps at 256
module vga_scan_engine #(
  parameter int   CLK_DIV     = vga_scan_pkg::CLK_DIV,
  parameter int   H_VIS       = vga_scan_pkg::H_VIS,
  parameter int   H_FP        = vga_scan_pkg::H_FP,
  parameter int   H_SYNC      = vga_scan_pkg::H_SYNC,
  parameter int   H_BP        = vga_scan_pkg::H_BP,
  parameter int   V_VIS       = vga_scan_pkg::V_VIS,
  parameter int   V_FP        = vga_scan_pkg::V_FP,
  parameter int   V_SYNC      = vga_scan_pkg::V_SYNC,
  parameter int   V_BP        = vga_scan_pkg::V_BP,
  parameter logic SYNC_ACTIVE = vga_scan_pkg::SYNC_ACTIVE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CONFIG_COLOURS,
  output logic        DPR_CLK,
  output logic [14:0] VGA_ADDR,
  input  logic        VGA_DATA,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_COLOUR,
  output logic        FRAME_START,
  output logic [7:0]  FRAME_COUNT
);
  import vga_scan_pkg::*;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Address fields: display coordinate divided by 4 selects the buffer pixel.
  localparam int L_COL_W = $clog2(FB_COLS);
  localparam int L_ROW_W = $clog2(FB_ROWS);

  logic [DIV_W-1:0]    r_div_cnt;
  logic                w_tick;
  logic [CNT_W-1:0]    w_h;
  logic [CNT_W-1:0]    w_v;
  logic                w_h_wrap;
  logic                w_v_wrap;
  logic                w_v_en;
  logic                w_hs_raw;
  logic                w_vs_raw;
  logic                w_h_vis;
  logic                w_v_vis;
  logic                w_vis_raw;
  logic [14:0]         r_addr;
  logic [PIPE_LAT-1:0] r_hs_dly;
  logic [PIPE_LAT-1:0] r_vs_dly;
  logic                r_vis_d1;
  logic [7:0]          r_colour;
  logic                r_frame_start;
  logic [7:0]          r_frame_count;
  logic                w_unused;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign w_tick  = (r_div_cnt == L_DIV_LAST);
  // Rising edge lands mid-pixel, half a pixel after the address changed.
  assign DPR_CLK = r_div_cnt[DIV_W-1];

  vga_axis_counter #(
    .VIS (H_VIS),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP)
  ) u_h_axis (
    .i_clk     (CLK),
    .i_rst_n   (RESET),
    .i_en      (w_tick),
    .o_count   (w_h),
    .o_wrap    (w_h_wrap),
    .o_sync_raw(w_hs_raw),
    .o_vis_raw (w_h_vis)
  );

  assign w_v_en = w_tick && w_h_wrap;

  vga_axis_counter #(
    .VIS (V_VIS),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP)
  ) u_v_axis (
    .i_clk     (CLK),
    .i_rst_n   (RESET),
    .i_en      (w_v_en),
    .o_count   (w_v),
    .o_wrap    (w_v_wrap),
    .o_sync_raw(w_vs_raw),
    .o_vis_raw (w_v_vis)
  );

  assign w_vis_raw = w_h_vis && w_v_vis;

  // Stage 1 (tick after counters = h,v): address out, sync/vis delayed once.
  // Stage 2 (next tick): read data has arrived on the DPR_CLK edge in between,
  // so the colour register samples it directly together with CONFIG_COLOURS.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_addr   <= '0;
      r_hs_dly <= '0;
      r_vs_dly <= '0;
      r_vis_d1 <= 1'b0;
      r_colour <= '0;
    end else if (w_tick) begin
      if (w_vis_raw) begin
        r_addr <= {w_v[L_ROW_W+1:2], w_h[L_COL_W+1:2]};
      end
      r_hs_dly <= {r_hs_dly[PIPE_LAT-2:0], w_hs_raw};
      r_vs_dly <= {r_vs_dly[PIPE_LAT-2:0], w_vs_raw};
      r_vis_d1 <= w_vis_raw;
      r_colour <= r_vis_d1 ? (VGA_DATA ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0])
                           : 8'h00;
    end
  end

  // w_v_wrap already implies tick && h_wrap, so it marks the frame wrap.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_start <= w_v_wrap;
      if (w_v_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign VGA_ADDR    = r_addr;
  assign VGA_HS      = r_hs_dly[PIPE_LAT-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign VGA_VS      = r_vs_dly[PIPE_LAT-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign VGA_COLOUR  = r_colour;
  assign FRAME_START = r_frame_start;
  assign FRAME_COUNT = r_frame_count;

  // Low address bits and the top count bits do not reach the buffer address.
  assign w_unused = ^{w_h[CNT_W-1:L_COL_W+2], w_h[1:0],
                      w_v[CNT_W-1:L_ROW_W+2], w_v[1:0]};

endmodule
